decoder_controller: RTL and testbench
=====================================

// Module: decoder_controller
// PURPOSE
//   Control unit for the decoder. It runs NUM_ROUNDS inverse rounds over the 5x5x64 state held in the
//   decoder datapath. Inverse round order: inverse RC (iota), inverse RE (chi), inverse PE (pi),
//   inverse RO (rho), inverse CP (theta). Rounds are indexed NUM_ROUNDS-1 down to 0.
//   Sits beside decoder_datapath under the decoder top level. It drives one-cycle start pulses to each
//   inverse-step unit and waits for that unit's finish pulse.
// PARAMETERS
//   NUM_ROUNDS  24  number of inverse rounds per decode
//   ITER_W      6   width of iteration output; must satisfy 2**ITER_W >= NUM_ROUNDS
// PORTS
//   clk         in   1       rising-edge clock
//   rst         in   1       synchronous, active-high reset
//   start       in   1       begin a decode; sampled only in IDLE
//   finish      out  1       one-cycle pulse when the decode is complete
//   busy        out  1       high from INIT through DONE inclusive
//   IRC_start   out  1       one-cycle start pulse to inverse-RC unit (same for the four below)
//   IRE_start   out  1       start pulse to inverse-RE unit
//   IPE_start   out  1       start pulse to inverse-PE unit
//   IRO_start   out  1       start pulse to inverse-RO unit
//   ICP_start   out  1       start pulse to inverse-CP unit
//   IRC_finish  in   1       done pulse from inverse-RC unit (same for the four below)
//   IRE_finish  in   1       done pulse from inverse-RE unit
//   IPE_finish  in   1       done pulse from inverse-PE unit
//   IRO_finish  in   1       done pulse from inverse-RO unit
//   ICP_finish  in   1       done pulse from inverse-CP unit
//   iteration   out  ITER_W  current round index; the datapath selects the round constant with it
// BEHAVIOUR
//   Reset: rst=1 at a clock edge -> state IDLE; iteration=0; all *_start, finish and busy = 0.
//     Reset takes priority over every other input, including mid-decode.
//   States: IDLE, INIT, then an S/W pair per step (IRC_S/W, IRE_S/W, IPE_S/W, IRO_S/W, ICP_S/W),
//     then NEXT and DONE. Moore outputs are registered by state.
//   IDLE: start=1 -> INIT. Otherwise stay.
//   INIT: iteration <= NUM_ROUNDS-1; -> IRC_S.
//   x_S: x_start=1 for exactly this cycle; -> x_W unconditionally.
//     Any x_finish seen in x_S is ignored.
//   x_W: wait for x_finish=1, then go to the next step's S state.
//     Step chain: IRC -> IRE -> IPE -> IRO -> ICP.
//   ICP_W on finish: iteration==0 -> DONE; else -> NEXT.
//   NEXT: iteration <= iteration-1; -> IRC_S.
//   DONE: finish=1 for this cycle; -> IDLE. iteration keeps 0 until the next INIT.
//   Only the finish input that matches the current W state is honoured. Stray or simultaneous finishes
//     from other units are ignored. Waits have no timeout.
//   start is ignored while busy; no queuing. start held high through DONE re-launches one cycle after IDLE.
//   Latency: with responders that pulse finish in the first W cycle, a round takes 10 cycles.
//     If start is sampled in cycle 0, INIT is cycle 1 and DONE/finish is cycle 265 (1+24*10+23 NEXT+1).
//   iteration never wraps: it decrements only in NEXT, and NEXT is reached only when iteration>0.
//   At most one *_start output is high in any cycle.
// TESTING
//   1 Reset: assert rst for 2 cycles with start=1 -> all outputs 0, iteration=0, stays IDLE.
//   2 Full decode with zero-delay responders: start pulse at cycle 0 -> finish high only at cycle 265;
//     each *_start pulses exactly 24 times; iteration sequence 23..0.
//   3 Responders with random 0-7 cycle finish delays -> step order strictly IRC,IRE,IPE,IRO,ICP per round;
//     no start re-issued while waiting.
//   4 Stray finish: pulse ICP_finish and IRC_finish during IRE_W -> no state change until IRE_finish arrives.
//   5 start pulse during round 12 -> ignored; one finish only; busy never drops early.
//   6 rst asserted in IPE_W of round 5 -> next cycle IDLE, busy=0, iteration=0; a new start gives a full 265-cycle decode.

Source files
------------

// File: rtl/decoder_controller.sv
// Decoder control unit: sequences the five inverse-step units over NUM_ROUNDS
// rounds, counting the round index down from NUM_ROUNDS-1 to 0.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start
// INIT   | load iteration with NUM_ROUNDS-1
// IRC_S  | pulse IRC_start
// IRC_W  | wait for IRC_finish
// IRE_S  | pulse IRE_start
// IRE_W  | wait for IRE_finish
// IPE_S  | pulse IPE_start
// IPE_W  | wait for IPE_finish
// IRO_S  | pulse IRO_start
// IRO_W  | wait for IRO_finish
// ICP_S  | pulse ICP_start
// ICP_W  | wait for ICP_finish, then end of round
// NEXT   | decrement iteration, start next round
// DONE   | pulse finish, return to IDLE
module decoder_controller #(
  parameter int NUM_ROUNDS = 24,
  parameter int ITER_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              finish,
  output logic              busy,
  output logic              IRC_start,
  output logic              IRE_start,
  output logic              IPE_start,
  output logic              IRO_start,
  output logic              ICP_start,
  input  logic              IRC_finish,
  input  logic              IRE_finish,
  input  logic              IPE_finish,
  input  logic              IRO_finish,
  input  logic              ICP_finish,
  output logic [ITER_W-1:0] iteration
);

  typedef enum logic [3:0] {
    IDLE, INIT,
    IRC_S, IRC_W,
    IRE_S, IRE_W,
    IPE_S, IPE_W,
    IRO_S, IRO_W,
    ICP_S, ICP_W,
    NEXT, DONE
  } state_t;

  localparam logic [ITER_W-1:0] LAST_ROUND = ITER_W'(NUM_ROUNDS - 1);

  state_t            state_q, state_d;
  logic [ITER_W-1:0] iteration_q, iteration_d;
  logic              finish_q, finish_d;
  logic              busy_q, busy_d;
  logic              irc_start_q, irc_start_d;
  logic              ire_start_q, ire_start_d;
  logic              ipe_start_q, ipe_start_d;
  logic              iro_start_q, iro_start_d;
  logic              icp_start_q, icp_start_d;

  // Next-state and round counter; only the finish of the unit being waited on advances.
  always_comb begin
    state_d     = state_q;
    iteration_d = iteration_q;
    case (state_q)
      IDLE:  if (start) state_d = INIT;
      INIT:  begin
        iteration_d = LAST_ROUND;
        state_d     = IRC_S;
      end
      IRC_S: state_d = IRC_W;
      IRC_W: if (IRC_finish) state_d = IRE_S;
      IRE_S: state_d = IRE_W;
      IRE_W: if (IRE_finish) state_d = IPE_S;
      IPE_S: state_d = IPE_W;
      IPE_W: if (IPE_finish) state_d = IRO_S;
      IRO_S: state_d = IRO_W;
      IRO_W: if (IRO_finish) state_d = ICP_S;
      ICP_S: state_d = ICP_W;
      ICP_W: begin
        if (ICP_finish) begin
          if (iteration_q == '0) state_d = DONE;
          else                   state_d = NEXT;
        end
      end
      NEXT:  begin
        iteration_d = iteration_q - ITER_W'(1);
        state_d     = IRC_S;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    busy_d      = (state_d != IDLE);
    finish_d    = (state_d == DONE);
    irc_start_d = (state_d == IRC_S);
    ire_start_d = (state_d == IRE_S);
    ipe_start_d = (state_d == IPE_S);
    iro_start_d = (state_d == IRO_S);
    icp_start_d = (state_d == ICP_S);
  end

  // State, counter and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      iteration_q <= '0;
      finish_q    <= 1'b0;
      busy_q      <= 1'b0;
      irc_start_q <= 1'b0;
      ire_start_q <= 1'b0;
      ipe_start_q <= 1'b0;
      iro_start_q <= 1'b0;
      icp_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      iteration_q <= iteration_d;
      finish_q    <= finish_d;
      busy_q      <= busy_d;
      irc_start_q <= irc_start_d;
      ire_start_q <= ire_start_d;
      ipe_start_q <= ipe_start_d;
      iro_start_q <= iro_start_d;
      icp_start_q <= icp_start_d;
    end
  end

  assign finish    = finish_q;
  assign busy      = busy_q;
  assign IRC_start = irc_start_q;
  assign IRE_start = ire_start_q;
  assign IPE_start = ipe_start_q;
  assign IRO_start = iro_start_q;
  assign ICP_start = icp_start_q;
  assign iteration = iteration_q;

endmodule

// File: tb/tb_decoder_controller.sv
// Bench for decoder_controller: responder models for the five step units and a
// scoreboard of expected (unit, round) start pulses followed by a finish token.
module tb_decoder_controller;

  localparam int NR       = 24;
  localparam int FIN_CODE = 5 * 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] fin;
  logic [4:0] st_w;
  logic       finish;
  logic       busy;
  logic [5:0] iteration;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int exp_cycle   = 0;
  int exp_busy    = -1;
  int last_iter   = -1;
  int last_unit   = -1;
  int c0          = 0;
  int fin_cycle   = 0;
  int max_delay   = 0;
  int stray_at    = -1;
  bit stray_en    = 1'b0;
  bit done        = 1'b0;
  int pend[5];
  int cnt[5];
  int start_cnt[5];
  int sb[$];

  decoder_controller #(.NUM_ROUNDS(NR), .ITER_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .finish     (finish),
    .busy       (busy),
    .IRC_start  (st_w[0]),
    .IRE_start  (st_w[1]),
    .IPE_start  (st_w[2]),
    .IRO_start  (st_w[3]),
    .ICP_start  (st_w[4]),
    .IRC_finish (fin[0]),
    .IRE_finish (fin[1]),
    .IPE_finish (fin[2]),
    .IRO_finish (fin[3]),
    .ICP_finish (fin[4]),
    .iteration  (iteration)
  );

  initial forever #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // One cycle: sample DUT at the falling edge, score it, then drive responders.
  task automatic step();
    logic [4:0] s;
    int code;
    @(negedge clk);
    cycle++;
    fin = '0;
    s = st_w;
    check_val("start_onehot", ($countones(s) <= 1) ? 1 : 0, 1);
    if (exp_busy >= 0) check_val("busy", int'(busy), exp_busy);
    for (int u = 0; u < 5; u++) begin
      if (s[u]) begin
        check_val("start_time", cycle, exp_cycle);
        check_val("sb_has_entry", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
          code = sb.pop_front();
          check_val("step_order", u * 64 + int'(iteration), code);
          last_iter = code % 64;
          last_unit = u;
        end
        start_cnt[u]++;
        pend[u] = 1;
        if (stray_en && u == 1) begin
          cnt[u]   = 4;
          stray_at = cycle + 1;
        end else begin
          cnt[u] = int'($urandom_range(max_delay, 0)) + 1;
        end
      end
    end
    if (finish) begin
      check_val("finish_time", cycle, exp_cycle);
      check_val("sb_has_entry", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        code = sb.pop_front();
        check_val("finish_order", code, FIN_CODE);
      end
      done      = 1'b1;
      fin_cycle = cycle;
      exp_busy  = 0;
    end
    for (int u = 0; u < 5; u++) begin
      if (pend[u] != 0 && !s[u]) begin
        cnt[u]--;
        if (cnt[u] == 0) begin
          pend[u] = 0;
          fin[u]  = 1'b1;
          if (u == 4) exp_cycle = (last_iter > 0) ? cycle + 2 : cycle + 1;
          else        exp_cycle = cycle + 1;
        end
      end
    end
    if (cycle == stray_at) begin
      fin[0] = 1'b1;
      fin[4] = 1'b1;
    end
  endtask

  task automatic launch(input int maxd, input bit stray);
    max_delay = maxd;
    stray_en  = stray;
    stray_at  = -1;
    sb.delete();
    for (int r = NR - 1; r >= 0; r--)
      for (int u = 0; u < 5; u++) sb.push_back(u * 64 + r);
    sb.push_back(FIN_CODE);
    for (int u = 0; u < 5; u++) begin
      pend[u]      = 0;
      start_cnt[u] = 0;
    end
    done      = 1'b0;
    last_iter = -1;
    last_unit = -1;
    c0        = cycle;
    exp_cycle = cycle + 2;
    exp_busy  = 1;
    start     = 1'b1;
  endtask

  task automatic run_decode(input int maxd, input bit stray, input int inj_round);
    bit injected;
    injected = 1'b0;
    launch(maxd, stray);
    for (int i = 0; i < 6000 && !done; i++) begin
      step();
      start = 1'b0;
      if (inj_round >= 0 && !injected && last_iter == inj_round) begin
        start    = 1'b1;
        injected = 1'b1;
      end
    end
    check_val("decode_done", int'(done), 1);
    if (maxd == 0 && !stray) check_val("latency", fin_cycle - c0, 265);
    for (int u = 0; u < 5; u++) check_val("start_count", start_cnt[u], NR);
    repeat (4) step();
    check_val("sb_drained", sb.size(), 0);
    check_val("iter_hold", int'(iteration), 0);
    check_val("idle_busy", int'(busy), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    fin   = '0;
    for (int u = 0; u < 5; u++) begin
      pend[u] = 0; cnt[u] = 0; start_cnt[u] = 0;
    end

    // reset held two cycles with start asserted
    step();
    step();
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_finish", int'(finish), 0);
    check_val("rst_starts", int'(st_w), 0);
    check_val("rst_iter", int'(iteration), 0);
    rst      = 1'b0;
    start    = 1'b0;
    exp_busy = 0;
    step();
    step();
    check_val("idle_starts", int'(st_w), 0);
    check_val("idle_iter", int'(iteration), 0);

    run_decode(0, 1'b0, -1);
    run_decode(7, 1'b0, -1);
    run_decode(0, 1'b1, -1);
    run_decode(3, 1'b0, 12);

    // abort in IPE_W of round 5, coinciding with the IPE finish pulse
    launch(0, 1'b0);
    for (int i = 0; i < 3000 && !(last_unit == 2 && last_iter == 5); i++) begin
      step();
      start = 1'b0;
    end
    check_val("reached_ipe5", (last_unit == 2 && last_iter == 5) ? 1 : 0, 1);
    step();
    rst      = 1'b1;
    exp_busy = -1;
    step();
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_iter", int'(iteration), 0);
    check_val("abort_starts", int'(st_w), 0);
    check_val("abort_finish", int'(finish), 0);
    rst = 1'b0;
    sb.delete();
    for (int u = 0; u < 5; u++) pend[u] = 0;
    exp_busy = 0;
    step();
    run_decode(0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
